// File: rtl/memory_write_dword.sv
// Issues one 1-4 byte write piece as one or two dword-aligned bus writes with lane-shifted data.
// Latency: first beat registered one cycle after capture; req_done combinational in final accept cycle.
// Backpressure: avm_waitrequest stalls the current beat with all bus outputs held.
module memory_write_dword (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_reset,
  input  logic        req_do,
  output logic        req_done,
  input  logic [31:0] req_address,
  input  logic [2:0]  req_length,
  input  logic [31:0] req_data,
  output logic [29:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  state_t      state_q, state_d;
  beat_t       bus_q, bus_d, beat2_q, beat2_d;
  logic        need2_q, need2_d;
  logic        write_q, write_d;
  logic        abort_q, abort_d;
  logic        pend_q, pend_d;
  logic        accept;
  logic [1:0]  off;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;

  // Both beats are derived from one 8-lane view: low half is beat 1, high half beat 2.
  assign off       = req_address[1:0];
  assign lane_mask = ((8'd1 << req_length) - 8'd1) << off;
  assign lane_data = {32'd0, req_data} << {off, 3'b000};
  assign accept    = write_q & ~avm_waitrequest;

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    beat2_d  = beat2_q;
    need2_d  = need2_q;
    write_d  = write_q;
    abort_d  = abort_q;
    pend_d   = 1'b0;
    req_done = pend_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        // The cycle carrying a pending zero-length done still sees req_do high; skip it.
        if (!pend_q && req_do && !wr_reset) begin
          if (req_length == 3'd0) begin
            pend_d = 1'b1;
          end else begin
            bus_d.addr    = req_address[31:2];
            bus_d.wdata   = lane_data[31:0];
            bus_d.be      = lane_mask[3:0];
            beat2_d.addr  = req_address[31:2] + 30'd1;
            beat2_d.wdata = lane_data[63:32];
            beat2_d.be    = lane_mask[7:4];
            need2_d       = |lane_mask[7:4];
            write_d       = 1'b1;
            state_d       = BEAT1;
          end
        end
      end
      BEAT1: begin
        if (wr_reset) abort_d = 1'b1;
        if (accept) begin
          if (need2_q) begin
            bus_d   = beat2_q;
            state_d = BEAT2;
          end else begin
            write_d  = 1'b0;
            abort_d  = 1'b0;
            state_d  = IDLE;
            req_done = ~abort_q & ~wr_reset;
          end
        end
      end
      BEAT2: begin
        if (wr_reset) abort_d = 1'b1;
        if (accept) begin
          write_d  = 1'b0;
          abort_d  = 1'b0;
          state_d  = IDLE;
          req_done = ~abort_q & ~wr_reset;
        end
      end
      default: begin
        write_d = 1'b0;
        abort_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bus_q   <= '0;
      beat2_q <= '0;
      need2_q <= 1'b0;
      write_q <= 1'b0;
      abort_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      beat2_q <= beat2_d;
      need2_q <= need2_d;
      write_q <= write_d;
      abort_q <= abort_d;
      pend_q  <= pend_d;
    end
  end

  assign avm_address    = bus_q.addr;
  assign avm_writedata  = bus_q.wdata;
  assign avm_byteenable = bus_q.be;
  assign avm_write      = write_q;

endmodule

// File: tb/tb_memory_write_dword.sv
// Randomized and directed bench for memory_write_dword against a byte-level bus-beat model.
module tb_memory_write_dword;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, wr_reset, req_do, req_done;
  logic [31:0] req_address, req_data;
  logic [2:0]  req_length;
  logic [29:0] avm_address;
  logic        avm_write, avm_waitrequest;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;

  int errors = 0;
  int checks = 0;

  beat_t q[$];
  bit    m_abort = 1'b0;
  bit    m_pend  = 1'b0;
  bit    m_rst   = 1'b1;
  bit    m_done  = 1'b0;

  memory_write_dword dut (
    .clk(clk), .rst(rst), .wr_reset(wr_reset), .req_do(req_do), .req_done(req_done),
    .req_address(req_address), .req_length(req_length), .req_data(req_data),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Places each data byte at its absolute byte address, then groups bytes into dwords.
  task automatic mk_beats(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d,
                          output beat_t b0, output beat_t b1, output int n);
    int off, pos, lane;
    off = int'(a[1:0]);
    b0 = '0;
    b1 = '0;
    b0.addr = a[31:2];
    b1.addr = a[31:2] + 30'd1;
    for (int i = 0; i < 4; i++) begin
      pos  = off + i;
      lane = pos % 4;
      if (pos < 4) begin
        b0.wdata[8*lane +: 8] = d[8*i +: 8];
        if (i < int'(len)) b0.be[lane] = 1'b1;
      end else begin
        b1.wdata[8*lane +: 8] = d[8*i +: 8];
        if (i < int'(len)) b1.be[lane] = 1'b1;
      end
    end
    n = (off + int'(len) > 4) ? 2 : 1;
  endtask

  // One clock cycle: inputs already driven; compare at negedge, then advance the model.
  task automatic cycle();
    bit    ed;
    beat_t b0, b1;
    int    n;
    @(negedge clk);
    ed = m_pend || (q.size() == 1 && !avm_waitrequest && !m_abort && !wr_reset);
    chk("req_done", 32'(req_done), 32'(ed));
    chk("avm_write", 32'(avm_write), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("avm_address", 32'(avm_address), 32'(q[0].addr));
      chk("avm_byteenable", 32'(avm_byteenable), 32'(q[0].be));
      chk("avm_writedata", avm_writedata, q[0].wdata);
    end else if (m_rst) begin
      chk("rst_address", 32'(avm_address), 32'd0);
      chk("rst_byteenable", 32'(avm_byteenable), 32'd0);
      chk("rst_writedata", avm_writedata, 32'd0);
    end
    m_done = ed;
    if (rst) begin
      q.delete();
      m_abort = 1'b0;
      m_pend  = 1'b0;
      m_rst   = 1'b1;
    end else if (m_pend) begin
      m_pend = 1'b0;
    end else if (q.size() > 0) begin
      if (wr_reset) m_abort = 1'b1;
      if (!avm_waitrequest) begin
        void'(q.pop_front());
        if (q.size() == 0) m_abort = 1'b0;
      end
    end else if (req_do && !wr_reset) begin
      if (req_length == 3'd0) begin
        m_pend = 1'b1;
      end else begin
        mk_beats(req_address, req_length, req_data, b0, b1, n);
        q.push_back(b0);
        if (n == 2) q.push_back(b1);
        m_rst = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d);
    req_address = a;
    req_length  = len;
    req_data    = d;
    req_do      = 1'b1;
  endtask

  initial begin
    beat_t pb0, pb1;
    int    pn, mx;
    bit    active;
    rst = 1'b1; wr_reset = 1'b0; req_do = 1'b0; avm_waitrequest = 1'b0;
    req_address = '0; req_length = '0; req_data = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Model pinned against hand-computed split beats.
    mk_beats(32'h2002, 3'd4, 32'h44332211, pb0, pb1, pn);
    chk("model_n", 32'(pn), 32'd2);
    chk("model_b0_wd", pb0.wdata, 32'h22110000);
    chk("model_b0_be", 32'(pb0.be), 32'hC);
    chk("model_b1_wd", pb1.wdata, 32'h00004433);
    chk("model_b1_be", 32'(pb1.be), 32'h3);

    // Aligned full dword.
    set_req(32'h1000, 3'd4, 32'hAABBCCDD); cycle();
    #1;
    chk("t1_addr", 32'(avm_address), 32'h400);
    chk("t1_be", 32'(avm_byteenable), 32'hF);
    chk("t1_wd", avm_writedata, 32'hAABBCCDD);
    chk("t1_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Single top byte.
    set_req(32'h1003, 3'd1, 32'h000000EE); cycle();
    #1;
    chk("t2_be", 32'(avm_byteenable), 32'h8);
    chk("t2_wd", avm_writedata, 32'hEE000000);
    chk("t2_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Split across two dwords.
    set_req(32'h2002, 3'd4, 32'h44332211); cycle();
    #1;
    chk("t3_b1_addr", 32'(avm_address), 32'h800);
    chk("t3_b1_done", 32'(req_done), 32'd0);
    cycle();
    #1;
    chk("t3_b2_addr", 32'(avm_address), 32'h801);
    chk("t3_b2_wd", avm_writedata, 32'h00004433);
    chk("t3_b2_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Split with three stall cycles on beat 1.
    set_req(32'h2002, 3'd4, 32'h44332211); cycle();
    avm_waitrequest = 1'b1; cycle(); cycle(); cycle();
    avm_waitrequest = 1'b0; cycle();
    #1;
    chk("t4_b2_addr", 32'(avm_address), 32'h801);
    chk("t4_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Abort during beat 1: both beats still issued, no done; next request completes.
    set_req(32'h2002, 3'd4, 32'h44332211); cycle();
    wr_reset = 1'b1; req_do = 1'b0; cycle();
    wr_reset = 1'b0;
    #1;
    chk("t5_b2_addr", 32'(avm_address), 32'h801);
    chk("t5_no_done", 32'(req_done), 32'd0);
    cycle(); cycle();
    set_req(32'h3001, 3'd2, 32'h0000BEEF); cycle();
    #1;
    chk("t5_next_be", 32'(avm_byteenable), 32'h6);
    chk("t5_next_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Zero length.
    set_req(32'h10, 3'd0, 32'h12345678); cycle();
    #1;
    chk("t6_no_write", 32'(avm_write), 32'd0);
    chk("t6_done", 32'(req_done), 32'd1);
    cycle(); req_do = 1'b0; cycle();

    // Synchronous reset during beat 2.
    set_req(32'h2002, 3'd4, 32'h44332211); cycle(); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; req_do = 1'b0;
    #1;
    chk("t7_write", 32'(avm_write), 32'd0);
    chk("t7_addr", 32'(avm_address), 32'd0);
    cycle();

    active = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (m_done || rst || wr_reset) active = 1'b0;
      rst             = ($urandom % 400) == 0;
      wr_reset        = ($urandom % 25) == 0;
      avm_waitrequest = ($urandom % 3) == 0;
      if (!active) begin
        req_length  = 3'($urandom % 5);
        mx          = 16 - ((req_length == 3'd0) ? 1 : int'(req_length));
        req_address = $urandom;
        req_address[3:0] = 4'($urandom_range(0, mx));
        req_data    = $urandom;
        if (($urandom % 3) != 0) active = 1'b1;
      end
      req_do = active;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_write_dword.md
# memory_write_dword

Downstream stage of the line-splitting write path: accepts one translated physical write piece (1–4 bytes, never crossing a 16-byte line) and issues it to the data bus as one or two dword-aligned Avalon-style writes with byte enables and lane-shifted data. Uses the same do/done request convention as its upstream neighbour, and honours the write-reset abort rule: a reset during operation completes bus traffic but suppresses done.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_reset  in  1  abort current request; done suppressed
- req_do  in  1  request valid; held until req_done
- req_done  out  1  one-cycle pulse, request fully written
- req_address  in  32  physical byte address
- req_length  in  3  byte count, 0–4
- req_data  in  32  write bytes, LSB-first (byte 0 = req_data[7:0])
- avm_address  out  30  dword address (byte address [31:2])
- avm_write  out  1  bus write strobe
- avm_writedata  out  32  lane-aligned data
- avm_byteenable  out  4  lane enables
- avm_waitrequest  in  1  bus stall; hold all avm outputs while high with avm_write

## Operation
- States: IDLE, BEAT1, BEAT2.
- IDLE:
  - On req_do && ~wr_reset, capture off = address[1:0], len, data, and dword = address[31:2].
  - len==0: go IDLE with no bus write, and pulse req_done the next cycle (done_pending flag).
  - Otherwise load the beat-1 avm outputs, set avm_write, and go BEAT1.
- Beat 1:
  - avm_address = dword.
  - avm_byteenable = (((1<<len)-1) << off)[3:0].
  - avm_writedata = data << 8*off, truncated to 32 bits.
- need2 = off+len > 4.
- Beat 2:
  - avm_address = dword+1, with no wrap logic; upstream guarantees the piece stays in its 16-byte line.
  - len2 = off+len-4.
  - avm_byteenable = (1<<len2)-1.
  - avm_writedata = data >> 8*(4-off).
- BEAT1, accept (avm_write && ~avm_waitrequest):
  - If need2: load the beat-2 outputs and go BEAT2.
  - Otherwise: drop avm_write, go IDLE, and assert req_done in the accept cycle unless aborted.
- BEAT2, accept: drop avm_write, go IDLE, and assert req_done in the accept cycle unless aborted.
- Abort flag:
  - Set by wr_reset while state != IDLE; cleared on entry to IDLE.
  - An issued beat is never withdrawn. BEAT2 is still issued after an abort in BEAT1, so the bus sees a consistent pair.
  - req_done is suppressed if the abort flag is set or wr_reset is high in the final accept cycle.
- wr_reset in IDLE blocks acceptance of req_do that cycle.
- Upstream deasserts req_do the cycle after req_done. If req_do is still high in IDLE, it is treated as a new request.
- req_address, req_length and req_data are don't-care after capture.

## Timing
- Reset values:
  - state IDLE; abort 0; done_pending 0.
  - avm_write 0, avm_address 0, avm_writedata 0, avm_byteenable 0; req_done 0.
- avm_* are registered; req_done is combinational from state, avm_waitrequest and abort.
- Cycle 0 req_do accepted → cycle 1 avm_write=1.
- Single beat, no wait: req_done in cycle 1.
- Two beats, no wait: beat 2 in cycle 2, req_done in cycle 2.
- Each waitrequest cycle adds one cycle of latency. avm outputs are stable while stalled.
- Minimum req_do-to-req_done latency is 1 cycle, and req_done is never in the same cycle as acceptance.
- Back-to-back: a new request can be captured in the cycle after req_done. The avm_write gap between requests is therefore 1 cycle.
- rst mid-operation drops avm_write in the next cycle. The system-level reset makes this acceptable.

## Test plan
- addr 0x1000, len 4, data 0xAABBCCDD, waitrequest 0 → cycle 1: avm_address 0x400, be 0xF, wdata 0xAABBCCDD; req_done cycle 1.
- addr 0x1003, len 1, data 0x000000EE → one beat: be 0x8, wdata 0xEE000000, done cycle 1.
- addr 0x2002, len 4, data 0x44332211 → two beats, done in cycle 2:
  - Beat 1: 0x800, be 0xC, wdata 0x22110000.
  - Beat 2: 0x801, be 0x3, wdata 0x00004433.
- addr 0x2002, len 4, waitrequest high 3 cycles on beat 1 → beat-1 outputs held constant for 4 cycles; beat 2 in cycle 5; done cycle 5.
- Same split request with wr_reset pulsed in cycle 1 → both beats still appear with identical values; req_done never asserts; a following request at addr 0x3001, len 2 completes normally (be 0x6).
- len 0 at addr 0x10 → no avm_write ever; req_done cycle 1. Separately, rst during BEAT2 → avm_write 0 next cycle; all outputs at reset values.
